// File: rtl/truth_table_sweeper.sv
// Sweeps every input combination of a combinational gate, captures its
// output into an MSB-first truth table and compares it with a latched expected code.
module truth_table_sweeper #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 2,
  localparam int TT_W  = 1 << N_IN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [TT_W-1:0] expected,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic [TT_W-1:0] truth_table,
  output logic            match,
  output logic [N_IN:0]   mismatch_count,
  output logic [1:0]      dbg_state
);

  // Handshake: start is a request sampled only in IDLE (ignored while busy,
  // including the DONE cycle); done is a one-cycle completion pulse and the
  // result outputs stay valid from done until the next accepted start.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0]      SETTLE_C = 8'(SETTLE);
  localparam logic [N_IN-1:0] LAST_IDX = '1;

  state_t            state, state_next;
  logic [N_IN-1:0]   idx;
  logic [7:0]        wait_cnt;
  logic [TT_W-1:0]   exp_lat;
  logic              sample;
  logic [N_IN-1:0]   bit_pos;
  logic              miss;
  logic [N_IN:0]     count_next;

  // MSB-first code: vector k lands in bit TT_W-1-k, which is simply ~k.
  assign bit_pos    = ~idx;
  assign sample     = (state == RUN) && (wait_cnt == SETTLE_C);
  assign miss       = dut_out ^ exp_lat[bit_pos];
  assign count_next = mismatch_count + {{N_IN{1'b0}}, miss};

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign dut_in    = (state == RUN) ? idx : '0;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (sample && (idx == LAST_IDX)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx            <= '0;
      wait_cnt       <= '0;
      exp_lat        <= '0;
      truth_table    <= '0;
      mismatch_count <= '0;
      match          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            exp_lat        <= expected;
            truth_table    <= '0;
            mismatch_count <= '0;
            match          <= 1'b0;
            idx            <= '0;
            wait_cnt       <= '0;
          end
        end
        RUN: begin
          if (sample) begin
            truth_table[bit_pos] <= dut_out;
            mismatch_count       <= count_next;
            wait_cnt             <= '0;
            // match must already be valid in the DONE cycle, so it is
            // resolved from the count that includes this final sample.
            if (idx == LAST_IDX) match <= (count_next == '0);
            else                 idx   <= idx + 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: idx <= '0;
      endcase
    end
  end

endmodule
